// File: rtl/cover_pkg.sv
// Shared types and helpers for the toggle-coverage collector.
package cover_pkg;

  // Widest counter/index any instance may use; per-instance widths are cast down.
  localparam int unsigned REC_IDX_W = 64;
  localparam int unsigned REC_CNT_W = 32;
  localparam int unsigned CNT_LIM_W = REC_CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dump_state_e;

  typedef struct packed {
    logic [REC_IDX_W-1:0] index;
    logic [REC_CNT_W-1:0] rise_cnt;
    logic [REC_CNT_W-1:0] fall_cnt;
  } cover_rec_t;

  // Increment v by one unless it already holds the all-ones value of a w-bit counter.
  function automatic logic [REC_CNT_W-1:0] sat_inc(input logic [REC_CNT_W-1:0] v,
                                                   input int unsigned w);
    logic [CNT_LIM_W-1:0] lim;
    lim = (CNT_LIM_W'(1) << w) - CNT_LIM_W'(1);
    if ({1'b0, v} >= lim) return v;
    return v + REC_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cover_toggle_cell.sv
// One monitored bit: edge detect, saturating rise/fall counters, sticky hit flags.
module cover_toggle_cell
  import cover_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_prev_valid,
  input  logic             i_sig,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_rise_cnt,
  output logic [CNT_W-1:0] o_fall_cnt,
  output logic             o_hit_both
);

  logic             r_prev;
  logic [CNT_W-1:0] r_rise_cnt;
  logic [CNT_W-1:0] r_fall_cnt;
  logic             r_rise_hit;
  logic             r_fall_hit;

  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_rise_inc;
  logic [CNT_W-1:0] w_fall_inc;

  assign w_rise     = i_enable & i_prev_valid & ~r_prev & i_sig;
  assign w_fall     = i_enable & i_prev_valid & r_prev & ~i_sig;
  assign w_rise_inc = CNT_W'(sat_inc(REC_CNT_W'(r_rise_cnt), CNT_W));
  assign w_fall_inc = CNT_W'(sat_inc(REC_CNT_W'(r_fall_cnt), CNT_W));

  // Sample history plus counters; a clear wins over old state but not over this cycle's edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_prev     <= 1'b0;
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
      r_rise_hit <= 1'b0;
      r_fall_hit <= 1'b0;
    end else begin
      if (i_enable) r_prev <= i_sig;
      if (i_clear) begin
        r_rise_cnt <= w_rise ? CNT_W'(1) : '0;
        r_fall_cnt <= w_fall ? CNT_W'(1) : '0;
        r_rise_hit <= w_rise;
        r_fall_hit <= w_fall;
      end else begin
        if (w_rise) begin
          r_rise_cnt <= w_rise_inc;
          r_rise_hit <= 1'b1;
        end
        if (w_fall) begin
          r_fall_cnt <= w_fall_inc;
          r_fall_hit <= 1'b1;
        end
      end
    end
  end

  assign o_rise_cnt = r_rise_cnt;
  assign o_fall_cnt = r_fall_cnt;
  assign o_hit_both = r_rise_hit & r_fall_hit;

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: per-bit cells, covered-bit popcount and a record dump port.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned COVER_INDEX   = 0,
  parameter int unsigned IDX_W         = 32,
  parameter int unsigned CLEAR_ON_READ = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           signal,
  input  logic                       dump_start,
  output logic                       dump_busy,
  output logic                       dump_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_index,
  output logic [CNT_W-1:0]           out_rise_cnt,
  output logic [CNT_W-1:0]           out_fall_cnt,
  output logic [WIDTH-1:0]           hit_both,
  output logic [$clog2(WIDTH+1)-1:0] covered_count
);

  localparam int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CCW   = $clog2(WIDTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WIDTH - 1);

  dump_state_e      r_state;
  dump_state_e      w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             r_prev_valid;
  logic [CCW-1:0]   r_covered;
  logic [CCW-1:0]   w_pop;

  logic             w_busy;
  logic             w_done;
  logic             w_valid;
  logic             w_accept;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] w_hit;
  logic [CNT_W-1:0] w_rise_arr [WIDTH];
  logic [CNT_W-1:0] w_fall_arr [WIDTH];

  assign w_accept = (r_state == SCAN) & out_ready;

  // Per-bit cells; the record being accepted is cleared when clear-on-read is enabled.
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    assign w_clear[g] = (CLEAR_ON_READ != 0) && w_accept && (r_ptr == PTR_W'(g));

    cover_toggle_cell #(
      .CNT_W(CNT_W)
    ) u_cell (
      .clock       (clock),
      .reset       (reset),
      .i_enable    (enable),
      .i_prev_valid(r_prev_valid),
      .i_sig       (signal[g]),
      .i_clear     (w_clear[g]),
      .o_rise_cnt  (w_rise_arr[g]),
      .o_fall_cnt  (w_fall_arr[g]),
      .o_hit_both  (w_hit[g])
    );
  end

  // prev_valid follows enable so the first enabled sample never counts as an edge.
  always_ff @(posedge clock) begin
    if (!reset) r_prev_valid <= 1'b0;
    else        r_prev_valid <= enable;
  end

  // Number of bits that have toggled both ways.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) w_pop = w_pop + CCW'(w_hit[i]);
  end

  // Covered count register, one cycle behind hit_both.
  always_ff @(posedge clock) begin
    if (!reset) r_covered <= '0;
    else        r_covered <= w_pop;
  end

  // Dump FSM state and record pointer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Dump FSM next state and status decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (dump_start) begin
          w_state_nxt = SCAN;
          w_ptr_nxt   = '0;
        end
      end
      SCAN: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
        if (out_ready) begin
          if (r_ptr == LAST_PTR) begin
            w_state_nxt = DONE;
            w_ptr_nxt   = '0;
          end else begin
            w_ptr_nxt = r_ptr + PTR_W'(1);
          end
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign dump_busy     = w_busy;
  assign dump_done     = w_done;
  assign out_valid     = w_valid;
  assign out_index     = IDX_W'(COVER_INDEX) + IDX_W'(r_ptr);
  assign out_rise_cnt  = w_rise_arr[r_ptr];
  assign out_fall_cnt  = w_fall_arr[r_ptr];
  assign hit_both      = w_hit;
  assign covered_count = r_covered;

endmodule
